dir_button_encoder: RTL

//  - Upstream stage of the 2-bit direction/command register.
//  - Takes four raw active-high push-buttons, then synchronises, debounces and edge-detects them.
//  - Encodes one accepted press into a 2-bit code that the downstream negedge register captures.
//  - dir_out changes only on posedge CLK, so it is stable at every negedge sample.

---
 rtl/dir_button_if.sv | 11 +
 rtl/dir_button_encoder.sv | 121 ++++++++++++
 2 files changed

// File: rtl/dir_button_if.sv
// Button/direction bundle between the push-button front end and its consumer.
// The master drives the raw buttons; the slave (the encoder) returns the accepted code.
interface dir_button_if;
   logic [3:0] btn_in;
   logic [1:0] dir_out;
   logic       dir_valid;
   logic       btn_held;

   modport master (output btn_in, input dir_out, input dir_valid, input btn_held);
   modport slave  (input btn_in, output dir_out, output dir_valid, output btn_held);
endinterface

// File: rtl/dir_button_encoder.sv
// Synchronises, debounces and edge-detects four push-buttons and encodes one accepted
// press into a 2-bit direction code; all outputs are registered and change on posedge CLK.
module dir_button_encoder #(
   parameter int DB_CYCLES = 50000,
   parameter int CNT_W     = 16
) (
   input  logic         CLK,
   input  logic         RST_N,
   dir_button_if.slave  bus
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_HELD  = 1'b1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   logic [3:0]       sync1_r;
   logic [3:0]       sync2_r;
   logic [3:0]       db_r;
   logic [3:0]       db_d_r;
   logic [3:0]       rise_r;
   logic [CNT_W-1:0] cnt_r [4];
   logic [0:0]       state_r;
   logic [1:0]       dir_r;
   logic             valid_r;

   // Lowest index wins: up > down > left > right.
   function automatic logic [1:0] pick_code(input logic [3:0] r);
      logic [1:0] code;
      if (r[0]) begin
         code = 2'b00;
      end else if (r[1]) begin
         code = 2'b01;
      end else if (r[2]) begin
         code = 2'b10;
      end else begin
         code = 2'b11;
      end
      return code;
   endfunction

   // Two-flop synchroniser per button.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
      end else begin
         sync1_r <= bus.btn_in;
         sync2_r <= sync1_r;
      end
   end

   // Per-button debounce: a level is accepted after DB_CYCLES consecutive differing samples.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         db_r <= 4'b0000;
         for (int i = 0; i < 4; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] == db_r[i]) begin
               cnt_r[i] <= '0;
            end else if (cnt_r[i] == CNT_LAST) begin
               db_r[i]  <= sync2_r[i];
               cnt_r[i] <= '0;
            end else begin
               cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Rising-edge detect, registered so the press lands exactly DB_CYCLES+3 edges after sampling.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         db_d_r <= 4'b0000;
         rise_r <= 4'b0000;
      end else begin
         db_d_r <= db_r;
         rise_r <= db_r & ~db_d_r;
      end
   end

   // Press FSM: accept one press in IDLE, then wait in HELD until every button is released.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_r <= ST_IDLE;
         dir_r   <= 2'b00;
         valid_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (rise_r != 4'b0000) begin
                  state_r <= ST_HELD;
                  dir_r   <= pick_code(rise_r);
                  valid_r <= 1'b1;
               end else begin
                  valid_r <= 1'b0;
               end
            end
            ST_HELD: begin
               valid_r <= 1'b0;
               if (db_r == 4'b0000) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_HELD;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dir_out   = dir_r;
   assign bus.dir_valid = valid_r;
   assign bus.btn_held  = (state_r == ST_HELD);

endmodule
